// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the dmem_lsu_mem load/store data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Lane mask over two consecutive words; the upper half selects second-beat lanes.
    function automatic logic [15:0] be_mask(input logic [2:0] off, input logic [3:0] nbytes);
        return ((16'd1 << nbytes) - 16'd1) << off;
    endfunction

    function automatic logic [63:0] load_ext(input logic [63:0] data, input logic [3:0] nbytes,
                                             input logic uns);
        logic [63:0] m;
        logic [5:0]  top;
        m   = (nbytes >= 4'd8) ? '1 : ((64'd1 << {nbytes, 3'b000}) - 64'd1);
        top = 6'({nbytes, 3'b000} - 7'd1);
        if (uns || !data[top]) begin
            return data & m;
        end
        return data | ~m;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-addressed synchronous RAM with per-lane write enables and registered read.
module dmem_lane_ram #(
    parameter int unsigned AW     = 10,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned LANES  = DWIDTH / 8
) (
    input  logic              clk,
    input  logic [AW-1:0]     i_addr,
    input  logic [LANES-1:0]  i_be,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [2**AW];
    logic [DWIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (i_be[l]) begin
                r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_lsu_mem.sv
// Byte-addressable data memory with load/store front end for the MEM stage.
// DMEM_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats (else trap them).
module dmem_lsu_mem
    import dmem_pkg::*;
#(
    parameter int unsigned AWIDTH = 12,
    parameter int unsigned DWIDTH = 32,
    localparam int unsigned LANES = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned OFFW = $clog2(LANES);
    localparam int unsigned WAW  = AWIDTH - OFFW;
    localparam int unsigned BEW  = 2 * LANES;

    logic [OFFW-1:0]     w_off;
    logic [WAW-1:0]      w_word;
    logic [3:0]          w_nbytes;
    logic                w_cross, w_illegal, w_fault, w_accept, w_start_split, w_busy;
    logic [BEW-1:0]      w_be2;
    logic [2*DWIDTH-1:0] w_wd2;

    logic [WAW-1:0]      w_ram_addr;
    logic [LANES-1:0]    w_ram_be;
    logic [DWIDTH-1:0]   w_ram_wd, w_ram_q, w_lo, w_shift, w_ext;

    logic                r_rsp_valid, r_err, r_load, r_uns, r_split, r_we;
    logic [OFFW-1:0]     r_off;
    logic [3:0]          r_nbytes;
    logic [WAW-1:0]      r_word_hi;
    logic [LANES-1:0]    r_be_hi;
    logic [DWIDTH-1:0]   r_wd_hi, r_beat1;

    assign w_off     = req_addr[OFFW-1:0];
    assign w_word    = req_addr[AWIDTH-1:OFFW];
    assign w_nbytes  = 4'd1 << req_size;
    assign w_cross   = (5'(w_off) + 5'(w_nbytes)) > 5'(LANES);
    assign w_illegal = (req_size == SZ_D) && (DWIDTH == 32);
    assign w_accept  = req_valid && req_ready;
    assign w_be2     = BEW'(be_mask(3'(w_off), w_nbytes));
    assign w_wd2     = {{DWIDTH{1'b0}}, req_wdata} << {w_off, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
    state_t r_state, w_state_nxt;

    assign w_fault = w_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_split) w_state_nxt = SPLIT;
            SPLIT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_busy = (r_state == SPLIT);
`else
    assign w_fault = w_illegal || w_cross;
    assign w_busy  = 1'b0;
`endif

    assign w_start_split = w_accept && w_cross && !w_fault;
    assign req_ready     = !rst && !w_busy;

    always_comb begin
        w_ram_addr = w_word;
        w_ram_be   = '0;
        w_ram_wd   = w_wd2[DWIDTH-1:0];
        if (w_busy) begin
            w_ram_addr = r_word_hi;
            w_ram_be   = r_we ? r_be_hi : '0;
            w_ram_wd   = r_wd_hi;
        end else if (w_accept && req_we && !w_fault) begin
            w_ram_be   = w_be2[LANES-1:0];
        end
    end

    dmem_lane_ram #(
        .AW     (WAW),
        .DWIDTH (DWIDTH),
        .LANES  (LANES)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wd),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_load      <= 1'b0;
            r_uns       <= 1'b0;
            r_split     <= 1'b0;
            r_we        <= 1'b0;
            r_off       <= '0;
            r_nbytes    <= '0;
            r_word_hi   <= '0;
            r_be_hi     <= '0;
            r_wd_hi     <= '0;
            r_beat1     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_busy) begin
                // First-beat word is held so the second read can land in the RAM register.
                r_beat1     <= w_ram_q;
                r_split     <= 1'b1;
                r_rsp_valid <= 1'b1;
            end else if (w_accept) begin
                r_off    <= w_off;
                r_nbytes <= w_nbytes;
                r_uns    <= req_unsigned;
                r_load   <= !req_we && !w_fault;
                r_err    <= w_fault;
                r_split  <= 1'b0;
                if (w_start_split) begin
                    r_we      <= req_we;
                    r_word_hi <= w_word + WAW'(1);
                    r_be_hi   <= w_be2[BEW-1:LANES];
                    r_wd_hi   <= w_wd2[2*DWIDTH-1:DWIDTH];
                end else begin
                    r_rsp_valid <= 1'b1;
                end
            end
        end
    end

    assign w_lo      = r_split ? r_beat1 : w_ram_q;
    assign w_shift   = DWIDTH'({w_ram_q, w_lo} >> {r_off, 3'b000});
    assign w_ext     = DWIDTH'(load_ext(64'(w_shift), r_nbytes, r_uns));
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_valid && r_err;
    assign rsp_rdata = (r_rsp_valid && r_load) ? w_ext : '0;

endmodule

// File: tb/tb_dmem_lsu_mem.sv
// Self-checking bench for dmem_lsu_mem against a byte-array reference model.
module tb_dmem_lsu_mem;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MEMB = 4096;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;

    int checks, errors;
    logic [7:0] mref [MEMB];

    dmem_lsu_mem #(
        .AWIDTH (AW),
        .DWIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [11:0] a;
        logic [31:0] d;
        bit          kchk;
        logic [31:0] kval;
    } op_t;

    // Reference: an access touches nbytes consecutive byte addresses modulo memory size.
    function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [11:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rd, output logic err, output int lat);
        int nb = 1 << size;
        int off = int'(addr) % 4;
        logic [63:0] v;
        rd = '0; err = 1'b0; lat = 1;
        if (size == 2'd3) begin err = 1'b1; return; end
        if (off + nb > 4) begin
            if (!SPLIT_EN) begin err = 1'b1; return; end
            lat = 2;
        end
        if (we) begin
            for (int i = 0; i < nb; i++) mref[(int'(addr) + i) % MEMB] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (64'(mref[(int'(addr) + i) % MEMB]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
            rd = v[31:0];
        end
    endfunction

    // Issues one request from a negedge and observes the response; ends on a negedge.
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output logic rdy_pre, output logic rdy_post, output int lat,
                          output logic [31:0] rd, output logic err, output logic extra);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        rdy_pre = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdy_post = req_ready;
        lat = 0; rd = '0; err = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (rsp_valid) begin lat = k; rd = rsp_rdata; err = rsp_err; break; end
        end
        @(posedge clk); #1;
        extra = rsp_valid;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks += 4;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_hold got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_hold got %b want 0", rsp_valid); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", rsp_valid); end
        @(negedge clk);
    endtask

    // Fills memory with back-to-back word stores, then a mixed non-crossing stream.
    task automatic test_back_to_back();
        logic [31:0] erd, d;
        logic eerr, w, u;
        logic [1:0] sz;
        logic [11:0] a;
        int elat;
        for (int i = 0; i < 1024 + 2 + 64; i++) begin
            u = 1'b0;
            if (i < 1024) begin
                w = 1'b1; sz = 2'd2; a = 12'(i * 4); d = $urandom;
            end else if (i == 1024) begin
                w = 1'b1; sz = 2'd2; a = 12'h020; d = 32'h12345678;
            end else if (i == 1025) begin
                w = 1'b0; sz = 2'd2; a = 12'h020; d = '0;
            end else begin
                w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 2));
                a = 12'($urandom_range(0, 127)) & ~((12'd1 << sz) - 12'd1);
                d = $urandom;
            end
            req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
            req_addr = a; req_wdata = d;
            checks++;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready op %0d got %b want 1", i, req_ready); end
            model_op(w, sz, u, a, d, erd, eerr, elat);
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== eerr || rsp_rdata !== erd) begin
                errors++;
                $display("FAIL b2b_rsp op %0d got v=%b e=%b d=%h want v=1 e=%b d=%h",
                         i, rsp_valid, rsp_err, rsp_rdata, eerr, erd);
            end
            if (i == 1025) begin
                checks++;
                if (rsp_rdata !== 32'h12345678) begin
                    errors++; $display("FAIL b2b_load got %h want 12345678", rsp_rdata);
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_directed();
        op_t tbl[$];
        logic rp, rq, er, ex, eerr;
        logic [31:0] rd, erd;
        int lat, elat;
        tbl.push_back('{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 1'b1, 32'hFFFFFFDE});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 1'b1, 32'h000000DE});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 12'h012, 32'h0, 1'b1, 32'hFFFFDEAD});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 12'h011, 32'h55, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b1, 32'hDEAD55EF});
        tbl.push_back('{1'b1, 2'd3, 1'b0, 12'h040, 32'hFFFFFFFF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 12'h01E, 32'hA1B2C3D4, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 12'h01C, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 12'h01E, 32'h0, SPLIT_EN, 32'hA1B2C3D4});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 12'hFFF, 32'h0000BEEF, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 12'hFFF, 32'h0, SPLIT_EN, 32'h000000EF});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 12'h000, 32'h0, SPLIT_EN, 32'h000000BE});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 12'h005, 32'h00008001, 1'b0, 32'h0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 12'h005, 32'h0, 1'b1, 32'hFFFF8001});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 12'h005, 32'h0, 1'b1, 32'h00008001});
        foreach (tbl[i]) begin
            run_op(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, rp, rq, lat, rd, er, ex);
            model_op(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, erd, eerr, elat);
            checks += 6;
            if (rp !== 1'b1) begin errors++; $display("FAIL dir_ready op %0d got %b want 1", i, rp); end
            if (lat != elat) begin errors++; $display("FAIL dir_latency op %0d got %0d want %0d", i, lat, elat); end
            if (rq !== (elat == 1)) begin errors++; $display("FAIL dir_ready_after op %0d got %b want %b", i, rq, elat == 1); end
            if (rd !== erd) begin errors++; $display("FAIL dir_rdata op %0d got %h want %h", i, rd, erd); end
            if (er !== eerr) begin errors++; $display("FAIL dir_err op %0d got %b want %b", i, er, eerr); end
            if (ex !== 1'b0) begin errors++; $display("FAIL dir_pulse op %0d got %b want 0", i, ex); end
            if (tbl[i].kchk) begin
                checks++;
                if (rd !== tbl[i].kval) begin errors++; $display("FAIL dir_const op %0d got %h want %h", i, rd, tbl[i].kval); end
            end
        end
    endtask

    task automatic test_random(input int n);
        logic rp, rq, er, ex, eerr, w, u;
        logic [1:0] sz;
        logic [11:0] a;
        logic [31:0] d, rd, erd;
        int lat, elat;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7)) : 12'($urandom_range(0, 63));
            d = $urandom;
            run_op(w, sz, u, a, d, rp, rq, lat, rd, er, ex);
            model_op(w, sz, u, a, d, erd, eerr, elat);
            checks += 6;
            if (rp !== 1'b1) begin errors++; $display("FAIL rnd_ready op %0d got %b want 1", i, rp); end
            if (lat != elat) begin errors++; $display("FAIL rnd_latency op %0d a=%h sz=%0d got %0d want %0d", i, a, sz, lat, elat); end
            if (rq !== (elat == 1)) begin errors++; $display("FAIL rnd_ready_after op %0d got %b want %b", i, rq, elat == 1); end
            if (rd !== erd) begin errors++; $display("FAIL rnd_rdata op %0d we=%b a=%h sz=%0d u=%b got %h want %h", i, w, a, sz, u, rd, erd); end
            if (er !== eerr) begin errors++; $display("FAIL rnd_err op %0d got %b want %b", i, er, eerr); end
            if (ex !== 1'b0) begin errors++; $display("FAIL rnd_pulse op %0d got %b want 0", i, ex); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d, erd, rd;
        logic [11:0] a;
        logic eerr, rp, rq, er, ex;
        int elat, lat;
        d = $urandom;
        a = SPLIT_EN ? 12'h02E : 12'h030;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = a; req_wdata = d;
        // Only the first beat of an interrupted split store reaches memory.
        if (SPLIT_EN) model_op(1'b1, 2'd1, 1'b0, 12'h02E, d, erd, eerr, elat);
        else          model_op(1'b1, 2'd2, 1'b0, a, d, erd, eerr, elat);
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== !SPLIT_EN) begin errors++; $display("FAIL mid_ready got %b want %b", req_ready, !SPLIT_EN); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== '0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", rsp_err); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", req_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stray_valid cycle %0d got %b want 0", k, rsp_valid); end
        end
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            a = (j == 0) ? 12'h02C : 12'h030;
            run_op(1'b0, 2'd2, 1'b0, a, '0, rp, rq, lat, rd, er, ex);
            model_op(1'b0, 2'd2, 1'b0, a, '0, erd, eerr, elat);
            checks += 3;
            if (rp !== 1'b1) begin errors++; $display("FAIL mid_load_ready a=%h got %b want 1", a, rp); end
            if (lat != 1) begin errors++; $display("FAIL mid_load_latency a=%h got %0d want 1", a, lat); end
            if (rd !== erd) begin errors++; $display("FAIL mid_load_rdata a=%h got %h want %h", a, rd, erd); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_back_to_back();
        test_directed();
        test_random(300);
        test_reset_mid_op();
        test_random(100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_mem.md
Name: dmem_lsu_mem

Overview:
Parametrised byte-addressable data memory with a load/store front end for the RISC-V core's MEM stage.
- Supports byte, half, word and (when DWIDTH=64) double accesses.
- Sign or zero extension on loads.
- Per-byte-lane writes.
- Valid/ready request handshake with a registered response.
- Accesses that cross a word boundary are split into two beats by a small FSM, or trapped (see Optional Feature).

Parameters:
AWIDTH, 12, byte-address width; memory size is 2^AWIDTH bytes.
DWIDTH, 32, data port and memory word width; legal values 32 or 64.
LANES, DWIDTH/8, byte lanes per word (derived, not overridden).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1=store, 0=load.
req_size  in  2  0=byte, 1=half, 2=word, 3=double (double legal only when DWIDTH=64).
req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
req_addr  in  AWIDTH  byte address.
req_wdata  in  DWIDTH  store data, right-justified.
rsp_valid  out  1  one-cycle pulse per accepted request.
rsp_rdata  out  DWIDTH  load result, extended; 0 for stores and errors.
rsp_err  out  1  qualified by rsp_valid; illegal size or trapped misalignment.

Behaviour:
- Handshake: a request is accepted on any posedge with req_valid && req_ready. Request fields are sampled only at acceptance.
- Reset (async assert): FSM goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while rst is high; req_ready=1 from the first cycle after deassert. Memory contents are not reset. Reset mid-split abandons the second beat; any first-beat store bytes already written stay written.
- Decode: off = addr mod LANES; nbytes = 1<<size; cross = off+nbytes > LANES.
- Aligned or non-crossing access (single beat): memory read/write happens at the acceptance edge; rsp_valid=1 in the next cycle (latency 1). A new request may be accepted in that same cycle, giving full back-to-back throughput.
- Store: byte enable mask = ((1<<nbytes)-1) << off; wdata is lane-shifted left by off*8. Unselected lanes are untouched.
- Load: the word is shifted right by off*8 and masked to nbytes.
  - If req_unsigned=0, the top selected bit is replicated to DWIDTH.
  - A full-width load ignores req_unsigned.
- Illegal size (size=3 with DWIDTH=32): no memory write; rsp_valid with rsp_err=1 and rdata=0 at latency 1.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 or later.
- FSM states:
  - IDLE: req_ready=1; a crossing request moves to SPLIT, everything else stays in IDLE.
  - SPLIT: req_ready=0; performs beat 2 at the next edge, then returns to IDLE.
- Split access:
  - Beat 1 covers lanes off..LANES-1 of word W at the acceptance edge.
  - Beat 2 covers lanes 0..(off+nbytes-LANES-1) of word W+1 at the following edge.
  - The word index wraps modulo 2^AWIDTH/LANES, so the top word wraps to word 0.
  - Load data from the two beats is concatenated, then extended.
  - rsp_valid fires 2 cycles after acceptance.
- rsp_valid is never held across cycles; there is no response back-pressure.

Optional Feature:
Macro DMEM_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split as above.
- Undefined: SPLIT state is not built and req_ready is held at 1 after reset. A crossing access performs no write and responds at latency 1 with rsp_err=1, rdata=0. Non-crossing misaligned accesses (e.g. half at offset 1) still succeed.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - FSM state enum (IDLE, SPLIT);
  - function for byte-enable generation;
  - function for load extension.
- Sub-module dmem_lane_ram: word-addressed synchronous RAM, depth 2^AWIDTH/LANES, width DWIDTH, with per-lane write enables and registered read. The top level owns the FSM, lane shifting and response registers.

Test Plan:
- SW 0xDEADBEEF @0x10, then LB @0x13 -> rdata 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; each rsp at latency 1.
- SB 0x55 @0x11 after above, then LW @0x10 -> 0xDEAD55EF (other lanes preserved).
- Back-to-back: SW 0x12345678 @0x20 at cycle N, LW @0x20 at N+1 -> req_ready stays 1; rsp at N+1 (store, rdata 0) and N+2 (0x12345678).
- With DMEM_MISALIGN_SPLIT_EN: SW 0xA1B2C3D4 @0x1E -> req_ready low for 1 cycle, rsp at +2; LW @0x1C -> 0xC3D4xxxx, LW @0x20 -> 0xxxxxA1B2; LW @0x1E -> 0xA1B2C3D4. Without the macro, the same store gives rsp_err=1 and memory is unchanged.
- Size=3 with DWIDTH=32 -> rsp_err=1, rdata 0, no write. Top-address wrap: split SH @ (2^AWIDTH-1) writes the last byte and byte 0.
- Assert rst in the SPLIT cycle of a crossing store -> outputs 0 immediately, req_ready 0; after release req_ready=1, FSM in IDLE, no stray rsp_valid.
